alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Drives the combinational 16-bit ALU (inputs Ain/Bin/ALUop; outputs out/Z) from a valid/ready command stream.
//  Loads operands into the A and B registers over separate cycles, the same way the datapath's loada/loadb do.
//  Captures the ALU result into the C register and Z into the status register, then returns both on a result handshake.
//  Sits between the future instruction controller and the ALU; it is the initiator end of the ALU interface.
// PARAMETERS
//  WIDTH   16  operand/result width; must match the ALU
//  CNT_W   8   width of the completed-operation counter
// PORTS
//  clk        in   1      rising-edge clock; only clock
//  reset_n    in   1      synchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_op     in   2      00 ADD, 01 SUB (A-B), 10 AND, 11 NOT B
//  cmd_a      in   WIDTH  operand A (ignored for op 11)
//  cmd_b      in   WIDTH  operand B
//  alu_ain    out  WIDTH  to ALU Ain; always the A register
//  alu_bin    out  WIDTH  to ALU Bin; always the B register
//  alu_op     out  2      to ALU ALUop; always the latched op
//  alu_out    in   WIDTH  from ALU out
//  alu_z      in   1      from ALU Z (1 iff alu_out==0)
//  res_valid  out  1      result available
//  res_ready  in   1      consumer takes result
//  res_data   out  WIDTH  C register
//  res_z      out  1      status register (Z)
//  done_count out  CNT_W  number of completed result handshakes
// BEHAVIOUR
//  Reset: the sampled edge with reset_n=0 sets state=IDLE. It also clears A, B, C, Z, the op and cmd buffers, and done_count to 0.
//   Reset overrides every other event, including mid-operation. Any in-flight command is dropped and no result is produced.
//  FSM states: IDLE, LOADA, LOADB, EXEC, DONE.
//   IDLE : cmd_ready=1. On cmd_valid&&cmd_ready, latch op, a and b into the buffers.
//          Next state is LOADB if op==11, otherwise LOADA.
//   LOADA: A <= buffered a; next state LOADB.
//   LOADB: B <= buffered b; next state EXEC.
//   EXEC : ALU is driven from A/B/op. On this edge C <= alu_out and Z <= alu_z; next state DONE.
//   DONE : res_valid=1. If res_ready, go to IDLE and done_count <= done_count+1.
//          Otherwise hold. res_data and res_z must stay stable while held.
//  cmd_ready=1 only in IDLE; res_valid=1 only in DONE. Both are registered-state decodes with no combinational path from inputs.
//  Latency, counted from the accept edge to the first cycle with res_valid=1:
//   4 cycles for ops 00/01/10; 3 cycles for op 11.
//  Op 11 skips LOADA, so the A register keeps its previous value.
//  Throughput: one command per (latency + 1 + res stall) cycles. No overlap of commands.
//  C and Z change only on the EXEC edge. They keep their values through IDLE until the next EXEC.
//  Arithmetic belongs to the ALU: ADD and SUB wrap modulo 2^WIDTH with no carry or overflow outputs.
//  done_count wraps from 2^CNT_W-1 to 0.
//  cmd_valid in a non-IDLE state is ignored and is not buffered. The source must hold it until cmd_ready.
//  cmd_valid in DONE while res_ready=1: the command is not accepted that cycle. It is accepted in the following IDLE cycle.
// TESTING
//  1. Reset: hold reset_n=0 for 2 edges mid-LOADB -> next cycle state IDLE, res_valid=0, res_data=0, res_z=0, done_count=0, cmd_ready=1.
//  2. ADD a=5, b=7, res_ready=1 -> res_valid rises 4 cycles after accept; res_data=12, res_z=0; done_count=1.
//  3. SUB a=10, b=3 -> 7, Z=0. Then SUB a=45, b=45 -> 0, Z=1.
//     Also check SUB a=0, b=1 -> 16'hFFFF, Z=0 (wrap).
//  4. AND a=15, b=60 -> 12. Then NOT b=16'h00FF -> 16'hFF00, latency 3.
//     alu_ain still equals 15 from the previous AND.
//  5. Backpressure: hold res_ready=0 for 10 cycles with cmd_valid=1 -> res_valid stays 1, res_data stable, cmd_ready=0.
//     After res_ready=1, the next command is accepted the cycle after.
//  6. Count wrap: run 256 back-to-back ADDs -> done_count returns to 0. Every result must match a reference model.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, result and ALU-drive signals between the sequencer and its surroundings.
// Both streams use plain valid/ready: a transfer happens on the rising edge where valid && ready; valid holds with stable data until then.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_ain;
    logic [WIDTH-1:0] alu_bin;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic             alu_z;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_z;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_z, res_ready,
        output cmd_ready, alu_ain, alu_bin, alu_op, res_valid, res_data, res_z
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_z, res_ready,
        input  cmd_ready, alu_ain, alu_bin, alu_op, res_valid, res_data, res_z
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command at a time: buffer, load A, load B, capture C/Z, hand back the result.
// Op 11 (NOT B) skips the A load, so A keeps whatever the previous command left there.
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_op_sequencer_if.master  bus,
    output logic [CNT_W-1:0]    done_count,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        LOADB = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, c_q, buf_a, buf_b;
    logic [1:0]       op_q;
    logic             z_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept, finish;

    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = (bus.cmd_op == 2'b11) ? LOADB : LOADA;
            end
            LOADA: state_d = LOADB;
            LOADB: state_d = EXEC;
            EXEC:  state_d = DONE;
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.cmd_valid && (state_q == IDLE);
    assign finish = bus.res_ready && (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= 1'b0;
            op_q    <= 2'b00;
            buf_a   <= '0;
            buf_b   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= bus.cmd_op;
                buf_a <= bus.cmd_a;
                buf_b <= bus.cmd_b;
            end
            if (state_q == LOADA) a_q <= buf_a;
            if (state_q == LOADB) b_q <= buf_b;
            // C/Z move only here, so res_data/res_z stay put through DONE and IDLE.
            if (state_q == EXEC) begin
                c_q <= bus.alu_out;
                z_q <= bus.alu_z;
            end
            if (finish) cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign bus.alu_ain  = a_q;
    assign bus.alu_bin  = b_q;
    assign bus.alu_op   = op_q;
    assign bus.res_data = c_q;
    assign bus.res_z    = z_q;
    assign done_count   = cnt_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, queue-based scoreboard, directed and random commands.
module tb_alu_op_sequencer;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [CNT_W-1:0] done_count;
    logic [2:0]       dbg_state;

    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .done_count (done_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External combinational ALU the sequencer drives.
    assign bus.alu_out = (bus.alu_op == 2'b00) ? bus.alu_ain + bus.alu_bin :
                         (bus.alu_op == 2'b01) ? bus.alu_ain - bus.alu_bin :
                         (bus.alu_op == 2'b10) ? bus.alu_ain & bus.alu_bin : ~bus.alu_bin;
    assign bus.alu_z   = (bus.alu_out == '0);

    // ---------------- scoreboard ----------------
    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];
    int             lat_q[$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             exp_done = 0;
    logic           prev_valid = 1'b0;
    logic [WIDTH:0] mon_e;
    int             mon_acc;
    int             mon_lat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH:0] ref_result(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = ~b;
        endcase
        return {(r == '0), r};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.res_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_acc = acc_q.pop_front();
                    mon_lat = lat_q.pop_front();
                    check_eq("res_data", 32'(bus.res_data), 32'(mon_e[WIDTH-1:0]));
                    check_eq("res_z", 32'(bus.res_z), 32'(mon_e[WIDTH]));
                    check_eq("latency", 32'(cyc - mon_acc), 32'(mon_lat));
                    check_eq("done_count", 32'(done_count), 32'(exp_done[CNT_W-1:0]));
                end
            end
            if (bus.res_valid && bus.res_ready) exp_done = exp_done + 1;
        end
        prev_valid = bus.res_valid;
    end

    // ---------------- driver tasks (called in the negedge phase) ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check_eq("cmd_accept_timeout", 32'(n), 32'd0);
            bus.cmd_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_result(op, a, b));
        acc_q.push_back(cyc);
        lat_q.push_back((op == 2'b11) ? 3 : 4);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_done = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b1;
        do_reset();
        check_eq("por_state", 32'(dbg_state), 32'd0);
        check_eq("por_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("por_res_valid", 32'(bus.res_valid), 32'd0);
        reset_n = 1'b1;

        // ADD 5 + 7
        send_cmd(2'b00, 16'd5, 16'd7);
        wait_drain();
        check_eq("add_data", 32'(bus.res_data), 32'd12);
        check_eq("add_z", 32'(bus.res_z), 32'd0);
        check_eq("add_count", 32'(done_count), 32'd1);

        // Reset held for two edges while in LOADB drops the command.
        send_cmd(2'b00, 16'h1111, 16'h2222);
        @(negedge clk);
        check_eq("mid_state_loadb", 32'(dbg_state), 32'd2);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        void'(lat_q.pop_back());
        do_reset();
        reset_n = 1'b1;
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_res_data", 32'(bus.res_data), 32'd0);
        check_eq("rst_res_z", 32'(bus.res_z), 32'd0);
        check_eq("rst_count", 32'(done_count), 32'd0);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_alu_ain", 32'(bus.alu_ain), 32'd0);
        repeat (6) @(negedge clk);
        check_eq("rst_no_result", 32'(bus.res_valid), 32'd0);

        // SUB, including zero result and wrap-around
        send_cmd(2'b01, 16'd10, 16'd3);
        wait_drain();
        check_eq("sub_data", 32'(bus.res_data), 32'd7);
        check_eq("sub_z", 32'(bus.res_z), 32'd0);
        send_cmd(2'b01, 16'd45, 16'd45);
        wait_drain();
        check_eq("sub_zero_data", 32'(bus.res_data), 32'd0);
        check_eq("sub_zero_z", 32'(bus.res_z), 32'd1);
        send_cmd(2'b01, 16'd0, 16'd1);
        wait_drain();
        check_eq("sub_wrap_data", 32'(bus.res_data), 32'h0000_FFFF);
        check_eq("sub_wrap_z", 32'(bus.res_z), 32'd0);

        // AND then NOT; NOT skips LOADA so A keeps 15
        send_cmd(2'b10, 16'd15, 16'd60);
        wait_drain();
        check_eq("and_data", 32'(bus.res_data), 32'd12);
        send_cmd(2'b11, 16'hABCD, 16'h00FF);
        wait_drain();
        check_eq("not_data", 32'(bus.res_data), 32'h0000_FF00);
        check_eq("not_keeps_a", 32'(bus.alu_ain), 32'd15);
        check_eq("count_after_not", 32'(done_count), 32'd5);

        // Backpressure with a new command already waiting
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        send_cmd(2'b00, 16'd100, 16'd23);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_valid_seen", 32'(bus.res_valid), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_a     = 16'hF0F0;
        bus.cmd_b     = 16'h0FF0;
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_hold_valid", 32'(bus.res_valid), 32'd1);
            check_eq("bp_hold_data", 32'(bus.res_data), 32'd123);
            check_eq("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        check_eq("done_no_accept", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check_eq("idle_after_done", 32'(bus.cmd_ready), 32'd1);
        send_cmd(2'b10, 16'hF0F0, 16'h0FF0);
        check_eq("bp_next_accepted", 32'(dbg_state), 32'd1);
        wait_drain();
        check_eq("bp_next_data", 32'(bus.res_data), 32'h0000_00F0);
        check_eq("bp_count", 32'(done_count), 32'd7);

        // 256 back-to-back random ADDs wrap done_count back to 0
        do_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_cmd(2'b00, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)));
        end
        wait_drain();
        check_eq("count_wrap", 32'(done_count), 32'd0);
        check_eq("handshakes", 32'(exp_done), 32'd256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
